// File: rtl/nbit_adder_pkg.sv
// ---------------------------------------------------------------------------
// nbit_adder_pkg
//   Shared helpers for the pipelined ripple adder: stage count, slice bit
//   boundaries and the per-stage control word that travels with each beat.
//   When NBIT_PIPE_ADDER_SUB_EN is defined the control word also carries the
//   add/subtract mode bit of its beat.
// ---------------------------------------------------------------------------
package nbit_adder_pkg;

    // Number of CHUNK-bit slices needed to cover WIDTH bits (last may be narrower).
    function automatic int num_stages(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Lowest operand bit handled by stage k.
    function automatic int slice_lo(input int k, input int chunk);
        return k * chunk;
    endfunction

    // Highest operand bit handled by stage k, clamped for the final narrow slice.
    function automatic int slice_hi(input int k, input int width, input int chunk);
        int hi;
        hi = (k + 1) * chunk - 1;
        if (hi > width - 1) begin
            hi = width - 1;
        end
        return hi;
    endfunction

    // Control held in every stage register: beat valid, carry out of the
    // slice computed in that stage, and (optionally) the beat's mode bit.
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef NBIT_PIPE_ADDER_SUB_EN
        logic sub;
`endif
    } stage_ctrl_t;

endpackage

// File: rtl/nbit_pipe_adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
//   Combinational W-bit ripple slice with carry in and carry out.
//   Ports:
//     a, b   in  W   slice operands
//     cin    in  1   carry into bit 0 of the slice
//     sum    out W   slice sum
//     cout   out 1   carry out of the top bit of the slice
// ---------------------------------------------------------------------------
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    assign total       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign {cout, sum} = total;

endmodule

// File: rtl/nbit_pipe_adder.sv
// ---------------------------------------------------------------------------
// nbit_pipe_adder
//   Pipelined ripple adder. WIDTH-bit unsigned operands are split into
//   CHUNK-bit slices; stage k adds slice k plus the carry registered by stage
//   k-1. Result bits already produced and operand bits not yet consumed ride
//   along with the beat, so each stage only stores what later stages need.
//   out_sum = {carry_out, sum} = A + B + cin, latency STAGES, one beat/cycle.
//
//   Handshake: a beat moves across a port when valid && ready are both high
//   on a rising edge. A stage may load when it is empty or when the stage
//   after it is loading too; the stage after the last one is the consumer
//   (out_ready). Stalled outputs hold out_valid/out_sum stable.
//
//   Optional feature (macro NBIT_PIPE_ADDER_SUB_EN): adds port in_sub. A beat
//   with in_sub=1 computes {1'b0,A} - {1'b0,B} - cin modulo 2^(WIDTH+1) as
//   A + ~B + !cin; out_sum[WIDTH]=1 then signals a borrow.
//
//   Ports:
//     clk        in   1        rising-edge clock
//     rst        in   1        synchronous active-high reset
//     in_valid   in   1        operand beat valid
//     in_ready   out  1        beat accepted this cycle (0 while rst)
//     in_a       in   WIDTH    operand A
//     in_b       in   WIDTH    operand B
//     in_cin     in   1        carry-in
//     in_sub     in   1        subtract mode (only with NBIT_PIPE_ADDER_SUB_EN)
//     out_valid  out  1        result valid
//     out_ready  in   1        downstream accepts result
//     out_sum    out  WIDTH+1  {carry_out, sum}
// ---------------------------------------------------------------------------
module nbit_pipe_adder
    import nbit_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef NBIT_PIPE_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);

    logic [STAGES-1:0] stage_valid;
    logic [STAGES:0]   adv;
    logic [WIDTH-1:0]  b_eff;
    stage_ctrl_t       ctrl_in0;

    // Subtraction is folded into the operands at entry: invert B and the
    // carry-in, then the whole pipeline is a plain adder.
    always_comb begin
        ctrl_in0       = '0;
        ctrl_in0.valid = in_valid;
`ifdef NBIT_PIPE_ADDER_SUB_EN
        ctrl_in0.carry = in_cin ^ in_sub;
        ctrl_in0.sub   = in_sub;
        b_eff          = in_sub ? ~in_b : in_b;
`else
        ctrl_in0.carry = in_cin;
        b_eff          = in_b;
`endif
    end

    // Back-to-front advance chain: a stage loads if it is empty or the
    // stage behind it (towards the output) is moving.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !stage_valid[k] || adv[k + 1];
        end
    end

    assign in_ready = adv[0] && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = slice_lo(k, CHUNK);
        localparam int HI   = slice_hi(k, WIDTH, CHUNK);
        localparam int SW   = HI - LO + 1;
        localparam int REM  = WIDTH - LO;   // operand bits still unconsumed on entry
        localparam int NREM = REM - SW;     // operand bits passed on to later stages

        logic [REM-1:0] a_in;
        logic [REM-1:0] b_in;
        stage_ctrl_t    ctrl_in;
        logic [HI:0]    s_nxt;
        logic [SW-1:0]  slice_sum;
        logic           slice_cout;
        stage_ctrl_t    ctrl_nxt;

        logic [HI:0]    s_q;
        stage_ctrl_t    ctrl_q;

        if (k == 0) begin : g_src
            assign a_in    = in_a;
            assign b_in    = b_eff;
            assign ctrl_in = ctrl_in0;
            assign s_nxt   = slice_sum;
        end else begin : g_src
            assign a_in    = g_stage[k-1].g_ops.a_q;
            assign b_in    = g_stage[k-1].g_ops.b_q;
            assign ctrl_in = g_stage[k-1].ctrl_q;
            assign s_nxt   = {slice_sum, g_stage[k-1].s_q};
        end

        adder_slice #(
            .W(SW)
        ) u_slice (
            .a    (a_in[SW-1:0]),
            .b    (b_in[SW-1:0]),
            .cin  (ctrl_in.carry),
            .sum  (slice_sum),
            .cout (slice_cout)
        );

        always_comb begin
            ctrl_nxt       = ctrl_in;
            ctrl_nxt.carry = slice_cout;
        end

        // Data only loads with a valid beat, so a bubble never overwrites
        // the value a stalled output is presenting.
        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl_q <= '0;
                s_q    <= '0;
            end else if (adv[k]) begin
                if (ctrl_in.valid) begin
                    ctrl_q <= ctrl_nxt;
                    s_q    <= s_nxt;
                end else begin
                    ctrl_q.valid <= 1'b0;
                end
            end
        end

        if (NREM > 0) begin : g_ops
            logic [NREM-1:0] a_q;
            logic [NREM-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv[k] && ctrl_in.valid) begin
                    a_q <= a_in[REM-1:SW];
                    b_q <= b_in[REM-1:SW];
                end
            end
        end

        assign stage_valid[k] = ctrl_q.valid;
    end

    logic final_carry;

`ifdef NBIT_PIPE_ADDER_SUB_EN
    // In subtract mode bit WIDTH of the extended difference is the inverse
    // of the adder carry: set means borrow.
    assign final_carry = g_stage[STAGES-1].ctrl_q.carry ^ g_stage[STAGES-1].ctrl_q.sub;
`else
    assign final_carry = g_stage[STAGES-1].ctrl_q.carry;
`endif

    assign out_valid = stage_valid[STAGES-1];
    assign out_sum   = {final_carry, g_stage[STAGES-1].s_q};

endmodule
